// File: rtl/score_keeper.sv
// Arcade score keeper: queues pellet/power/ghost events and adds their point values into a
// 5-digit BCD score one digit per cycle, committing all digits at once.
module score_keeper #(
  parameter int unsigned PELLET_TOTAL = 244,
  parameter int unsigned QDEPTH_MAX   = 7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_eaten,
  input  logic       level_start,
  input  logic       game_over,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hunds,
  output logic [3:0] thous,
  output logic [3:0] tenthous,
  output logic [7:0] pellet_count,
  output logic       all_eaten,
  output logic       extra_life,
  output logic       busy,
  output logic       q_overflow
);

  localparam logic [2:0] QMax = 3'(QDEPTH_MAX);

  typedef enum logic [1:0] {StIdle, StAdd, StCommit} state_e;

  state_e      state_q, state_d;
  logic [2:0]  pend_g_q, pend_g_d;
  logic [2:0]  pend_p_q, pend_p_d;
  logic [2:0]  pend_d_q, pend_d_d;
  logic [1:0]  chain_q, chain_d;
  logic [19:0] work_q, work_d;
  logic [19:0] addend_q, addend_d;
  logic [2:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [19:0] score_q, score_d;
  logic [7:0]  pcount_q, pcount_d;
  logic        all_q, all_d;
  logic        xlife_q, xlife_d;
  logic        life_used_q, life_used_d;
  logic        ovf_q, ovf_d;

  logic        ev_g, ev_p, ev_d;
  logic        deq_g, deq_p, deq_d, deq_any;
  logic        drop_g, drop_p, drop_d;
  logic        acc_p, acc_d;
  logic [19:0] ghost_add;
  logic [8:0]  pc_sum;
  logic [3:0]  work_dig, add_dig, new_dig;
  logic [4:0]  sum;

  // Returns {dropped, next_count}; a dequeue on the same edge frees the slot for the pulse.
  function automatic logic [3:0] pend_upd(input logic [2:0] cnt, input logic pulse,
                                          input logic deq);
    logic       drop;
    logic [2:0] nxt;
    drop = pulse && !deq && (cnt == QMax);
    nxt  = cnt;
    if (deq) nxt = nxt - 3'd1;
    if (pulse && !drop) nxt = nxt + 3'd1;
    return {drop, nxt};
  endfunction

  assign ev_g = ghost_eaten  & ~game_over;
  assign ev_p = power_eaten  & ~game_over;
  assign ev_d = pellet_eaten & ~game_over;

  assign deq_g   = (state_q == StIdle) && (pend_g_q != 3'd0);
  assign deq_p   = (state_q == StIdle) && (pend_g_q == 3'd0) && (pend_p_q != 3'd0);
  assign deq_d   = (state_q == StIdle) && (pend_g_q == 3'd0) && (pend_p_q == 3'd0) &&
                   (pend_d_q != 3'd0);
  assign deq_any = deq_g | deq_p | deq_d;

  always_comb begin
    {drop_g, pend_g_d} = pend_upd(pend_g_q, ev_g, deq_g);
    {drop_p, pend_p_d} = pend_upd(pend_p_q, ev_p, deq_p);
    {drop_d, pend_d_d} = pend_upd(pend_d_q, ev_d, deq_d);
  end

  assign acc_p = ev_p & ~drop_p;
  assign acc_d = ev_d & ~drop_d;
  assign ovf_d = ovf_q | drop_g | drop_p | drop_d;

  // Addend uses the pre-update index even when the chain is reset on the same edge.
  always_comb begin
    chain_d = chain_q;
    if (deq_g && (chain_q != 2'd3)) chain_d = chain_q + 2'd1;
    if (acc_p || level_start) chain_d = 2'd0;
  end

  always_comb begin
    unique case (chain_q)
      2'd0: ghost_add = 20'h00200;
      2'd1: ghost_add = 20'h00400;
      2'd2: ghost_add = 20'h00800;
      2'd3: ghost_add = 20'h01600;
      default: ghost_add = 20'h00200;
    endcase
  end

  always_comb begin
    pc_sum   = {1'b0, pcount_q} + {8'd0, acc_d} + {8'd0, acc_p};
    pcount_d = (pc_sum > 9'd255) ? 8'hff : pc_sum[7:0];
    all_d    = all_q | (32'(pcount_d) >= PELLET_TOTAL);
  end

  // Digit selected by idx for the current ADD cycle.
  always_comb begin
    work_dig = work_q[3:0];
    add_dig  = addend_q[3:0];
    case (idx_q)
      3'd1: begin work_dig = work_q[7:4];   add_dig = addend_q[7:4];   end
      3'd2: begin work_dig = work_q[11:8];  add_dig = addend_q[11:8];  end
      3'd3: begin work_dig = work_q[15:12]; add_dig = addend_q[15:12]; end
      3'd4: begin work_dig = work_q[19:16]; add_dig = addend_q[19:16]; end
      default: ;
    endcase
    sum = {1'b0, work_dig} + {1'b0, add_dig} + {4'd0, carry_q};
    new_dig = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    addend_d    = addend_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    score_d     = score_q;
    xlife_d     = 1'b0;
    life_used_d = life_used_q;
    unique case (state_q)
      StIdle: begin
        if (deq_any) begin
          addend_d = deq_g ? ghost_add : (deq_p ? 20'h00050 : 20'h00010);
          work_d   = score_q;
          idx_d    = 3'd0;
          carry_d  = 1'b0;
          state_d  = StAdd;
        end
      end
      StAdd: begin
        carry_d = (sum > 5'd9);
        case (idx_q)
          3'd0: work_d[3:0]   = new_dig;
          3'd1: work_d[7:4]   = new_dig;
          3'd2: work_d[11:8]  = new_dig;
          3'd3: work_d[15:12] = new_dig;
          3'd4: work_d[19:16] = new_dig;
          default: ;
        endcase
        if (idx_q == 3'd4) state_d = StCommit;
        else               idx_d   = idx_q + 3'd1;
      end
      StCommit: begin
        // A carry out of the top digit means the true sum exceeded 99999.
        score_d = carry_q ? 20'h99999 : work_q;
        if (!life_used_q && (score_q[19:16] == 4'd0) && (score_d[19:16] != 4'd0)) begin
          xlife_d     = 1'b1;
          life_used_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      pend_g_q    <= 3'd0;
      pend_p_q    <= 3'd0;
      pend_d_q    <= 3'd0;
      chain_q     <= 2'd0;
      work_q      <= 20'd0;
      addend_q    <= 20'd0;
      idx_q       <= 3'd0;
      carry_q     <= 1'b0;
      score_q     <= 20'd0;
      pcount_q    <= 8'd0;
      all_q       <= 1'b0;
      xlife_q     <= 1'b0;
      life_used_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_g_q    <= pend_g_d;
      pend_p_q    <= pend_p_d;
      pend_d_q    <= pend_d_d;
      chain_q     <= chain_d;
      work_q      <= work_d;
      addend_q    <= addend_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      score_q     <= score_d;
      pcount_q    <= pcount_d;
      all_q       <= all_d;
      xlife_q     <= xlife_d;
      life_used_q <= life_used_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ones         = score_q[3:0];
  assign tens         = score_q[7:4];
  assign hunds        = score_q[11:8];
  assign thous        = score_q[15:12];
  assign tenthous     = score_q[19:16];
  assign pellet_count = pcount_q;
  assign all_eaten    = all_q;
  assign extra_life   = xlife_q;
  assign busy         = (state_q != StIdle);
  assign q_overflow   = ovf_q;

endmodule
